// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - Camera Link base formatter shared constants, state encoding and width helpers
package cl_pkg;

   localparam logic [6:0] CL_XCLK_PATTERN = 7'b1100011;

   localparam int CL_LVAL_BIT = 24;
   localparam int CL_FVAL_BIT = 25;
   localparam int CL_DVAL_BIT = 26;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FV_PRE,
      ST_WAIT,
      ST_LINE,
      ST_HBLANK,
      ST_FV_POST
   } cl_state_e;

   function automatic int cl_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cl_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cl_sync_fifo.sv
// rtl/cl_sync_fifo.sv - single-clock FIFO with full/empty flags and asynchronous active-low reset
module cl_sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             wr;
   logic             rd;

   assign full_o    = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign wr        = wr_en_i & ~full_o;
   assign rd        = rd_en_i & ~empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Storage is not reset; a flush only needs the pointers and count cleared.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr, rd})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/cl_base_formatter.sv
// rtl/cl_base_formatter.sv - Camera Link base formatter: pixel FIFO, FVAL/LVAL/DVAL timing, 28-bit word split
// Optional test pattern generator enabled by defining CL_TEST_PATTERN_EN.
module cl_base_formatter
   import cl_pkg::*;
#(
   parameter int PIX_W       = 10,
   parameter int LINE_WORDS  = 1024,
   parameter int FRAME_LINES = 1024,
   parameter int HBLANK      = 16,
   parameter int FV_SETUP    = 8,
   parameter int FV_HOLD     = 8,
   parameter int FIFO_DEPTH  = 64
) (
   input  logic             gclk,
   input  logic             reset_n,
   input  logic             frame_trig,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [2*PIX_W-1:0] pix_data,
   input  logic             tp_en,
   output logic [6:0]       tx_x0,
   output logic [6:0]       tx_x1,
   output logic [6:0]       tx_x2,
   output logic [6:0]       tx_x3,
   output logic [6:0]       tx_xclk,
   output logic             frame_busy,
   output logic             line_stall,
   output logic             trig_drop
);

   localparam int WCW = cl_width(LINE_WORDS);
   localparam int LCW = cl_width(FRAME_LINES);
   localparam int TW  = cl_width(cl_max3(HBLANK, FV_SETUP, FV_HOLD));

   localparam logic [WCW-1:0] LAST_WORD   = WCW'(LINE_WORDS - 1);
   localparam logic [LCW-1:0] LAST_LINE   = LCW'(FRAME_LINES - 1);
   localparam logic [TW-1:0]  SETUP_LAST  = TW'(FV_SETUP - 1);
   localparam logic [TW-1:0]  HBLANK_LAST = TW'(HBLANK - 1);
   localparam logic [TW-1:0]  HOLD_LAST   = TW'(FV_HOLD - 1);

   cl_state_e          state_q;
   logic [WCW-1:0]     word_cnt_q;
   logic [LCW-1:0]     line_cnt_q;
   logic [TW-1:0]      tmr_q;
   logic [27:0]        word_q;
   logic [27:0]        word_d;
   logic               alive_q;
   logic               frame_busy_q;
   logic               line_stall_q;
   logic               trig_drop_q;

   logic [2*PIX_W-1:0] fifo_rd_data;
   logic [2*PIX_W-1:0] pix_word;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_wr;
   logic               fifo_rd;
   logic               tp_active;
   logic               data_avail;
   logic               in_line;
   logic               pop;

`ifdef CL_TEST_PATTERN_EN
   logic [PIX_W-1:0]   tp_a;

   assign tp_active = tp_en;
   assign tp_a      = PIX_W'({word_cnt_q, 1'b0});
   assign pix_word  = tp_active ? {tp_a | PIX_W'(1), tp_a} : fifo_rd_data;
`else
   logic               unused_tp_en;

   assign unused_tp_en = tp_en;
   assign tp_active    = 1'b0;
   assign pix_word     = fifo_rd_data;
`endif

   // alive_q holds ready and the clock pattern low until the first edge after reset release.
   assign pix_ready  = alive_q & ~fifo_full & ~tp_active;
   assign fifo_wr    = pix_valid & pix_ready;
   assign data_avail = ~fifo_empty | tp_active;
   assign in_line    = (state_q == ST_LINE);
   assign pop        = in_line & data_avail;
   assign fifo_rd    = pop & ~tp_active;

   cl_sync_fifo #(
      .WIDTH (2*PIX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (gclk),
      .rst_n     (reset_n),
      .wr_en_i   (fifo_wr),
      .wr_data_i (pix_data),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_comb begin
      word_d = '0;
      if (state_q != ST_IDLE) begin
         word_d[CL_FVAL_BIT] = 1'b1;
      end
      if (in_line) begin
         word_d[CL_LVAL_BIT] = 1'b1;
      end
      if (pop) begin
         word_d[CL_DVAL_BIT]   = 1'b1;
         word_d[2*PIX_W-1:0]   = pix_word;
      end
   end

   // WAIT is only occupied while the FIFO is empty, so a prefilled FIFO gives exact setup/blank lengths.
   always_ff @(posedge gclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         word_cnt_q   <= '0;
         line_cnt_q   <= '0;
         tmr_q        <= '0;
         word_q       <= '0;
         alive_q      <= 1'b0;
         frame_busy_q <= 1'b0;
         line_stall_q <= 1'b0;
         trig_drop_q  <= 1'b0;
      end else begin
         alive_q      <= 1'b1;
         word_q       <= word_d;
         line_stall_q <= in_line & ~data_avail;
         trig_drop_q  <= frame_trig & (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (frame_trig) begin
                  state_q      <= ST_FV_PRE;
                  tmr_q        <= '0;
                  word_cnt_q   <= '0;
                  line_cnt_q   <= '0;
                  frame_busy_q <= 1'b1;
               end
            end
            ST_FV_PRE: begin
               if (tmr_q == SETUP_LAST) begin
                  tmr_q   <= '0;
                  state_q <= data_avail ? ST_LINE : ST_WAIT;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (data_avail) begin
                  state_q <= ST_LINE;
               end
            end
            ST_LINE: begin
               if (pop) begin
                  if (word_cnt_q == LAST_WORD) begin
                     word_cnt_q <= '0;
                     tmr_q      <= '0;
                     if (line_cnt_q == LAST_LINE) begin
                        line_cnt_q <= '0;
                        state_q    <= ST_FV_POST;
                     end else begin
                        line_cnt_q <= line_cnt_q + 1'b1;
                        state_q    <= ST_HBLANK;
                     end
                  end else begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                  end
               end
            end
            ST_HBLANK: begin
               if (tmr_q == HBLANK_LAST) begin
                  tmr_q   <= '0;
                  state_q <= data_avail ? ST_LINE : ST_WAIT;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_FV_POST: begin
               if (tmr_q == HOLD_LAST) begin
                  tmr_q        <= '0;
                  state_q      <= ST_IDLE;
                  frame_busy_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_x0      = word_q[6:0];
   assign tx_x1      = word_q[13:7];
   assign tx_x2      = word_q[20:14];
   assign tx_x3      = word_q[27:21];
   assign tx_xclk    = alive_q ? CL_XCLK_PATTERN : 7'd0;
   assign frame_busy = frame_busy_q;
   assign line_stall = line_stall_q;
   assign trig_drop  = trig_drop_q;

endmodule

// File: tb/tb_cl_base_formatter.sv
// tb/tb_cl_base_formatter.sv - scoreboard bench for cl_base_formatter (small frame geometry)
module tb_cl_base_formatter;

   logic        gclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_trig = 1'b0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [19:0] pix_data = '0;
   logic        tp_en = 1'b0;
   logic [6:0]  tx_x0, tx_x1, tx_x2, tx_x3, tx_xclk;
   logic        frame_busy, line_stall, trig_drop;

   int          checks = 0;
   int          failures = 0;
   logic [19:0] sb_q[$];
   logic [2:0]  trace[$];
   int          exp_code[$];
   int          exp_len[$];
   bit          rec_en = 1'b0;
   int          stall_n = 0;
   int          drop_n = 0;
   bit          got_first = 1'b0;
   logic [27:0] first_w = '0;

   cl_base_formatter #(
      .PIX_W       (10),
      .LINE_WORDS  (4),
      .FRAME_LINES (2),
      .HBLANK      (2),
      .FV_SETUP    (3),
      .FV_HOLD     (3),
      .FIFO_DEPTH  (8)
   ) dut (
      .gclk       (gclk),
      .reset_n    (reset_n),
      .frame_trig (frame_trig),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .tp_en      (tp_en),
      .tx_x0      (tx_x0),
      .tx_x1      (tx_x1),
      .tx_x2      (tx_x2),
      .tx_x3      (tx_x3),
      .tx_xclk    (tx_xclk),
      .frame_busy (frame_busy),
      .line_stall (line_stall),
      .trig_drop  (trig_drop)
   );

   always #5 gclk = ~gclk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every DVAL word and records the frame timing trace.
   always @(negedge gclk) begin
      logic [27:0] w;
      if (reset_n === 1'b1) begin
         w = {tx_x3, tx_x2, tx_x1, tx_x0};
         check("reserved bits", {27'd0, w[27], w[23:20]}, 32'd0);
         if (w[26]) begin
            check("dval with expected word", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
               check("pixel word", w[19:0], sb_q.pop_front());
            end
         end else begin
            check("pixel zero without dval", w[19:0], 0);
         end
         if (rec_en) begin
            trace.push_back({w[26], w[24], w[25]});
            if (line_stall) stall_n++;
            if (trig_drop) drop_n++;
            if (w[26] && !got_first) begin
               got_first = 1'b1;
               first_w   = w;
            end
         end
      end
   end

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   task automatic write_word(input logic [19:0] d, output bit acc);
      pix_data  = d;
      pix_valid = 1'b1;
      acc       = pix_ready;
      if (acc) sb_q.push_back(d);
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic prefill9(input logic [19:0] base, output int acc_n);
      bit acc;
      acc_n = 0;
      for (int k = 0; k < 9; k++) begin
         write_word((k == 0 && base == 20'h0) ? {10'h2AB, 10'h155} : base + 20'(k * 'h1111), acc);
         if (acc) acc_n++;
      end
   endtask

   task automatic add_run(input int c, input int l);
      exp_code.push_back(c);
      exp_len.push_back(l);
   endtask

   task automatic add_normal_frame();
      exp_code.delete();
      exp_len.delete();
      add_run(1, 3);
      add_run(7, 4);
      add_run(1, 2);
      add_run(7, 4);
      add_run(1, 3);
   endtask

   task automatic start_frame();
      trace.delete();
      stall_n   = 0;
      drop_n    = 0;
      got_first = 1'b0;
      rec_en    = 1'b1;
      frame_trig = 1'b1;
      tick();
      frame_trig = 1'b0;
      check("busy after trig", frame_busy, 1);
   endtask

   task automatic wait_frame(input string nm);
      int n = 0;
      while (frame_busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check({nm, " frame done"}, frame_busy, 0);
      tick();
      tick();
      rec_en = 1'b0;
   endtask

   task automatic check_trace(input string nm);
      int rc[$];
      int rl[$];
      int n;
      foreach (trace[i]) begin
         if (trace[i] != 3'd0) begin
            if (rc.size() > 0 && rc[rc.size()-1] == int'(trace[i])) begin
               rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end else begin
               rc.push_back(int'(trace[i]));
               rl.push_back(1);
            end
         end
      end
      check({nm, " run count"}, rc.size(), exp_code.size());
      n = (rc.size() < exp_code.size()) ? rc.size() : exp_code.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s run%0d code", nm, i), rc[i], exp_code[i]);
         check($sformatf("%s run%0d len", nm, i), rl[i], exp_len[i]);
      end
      check({nm, " scoreboard drained"}, sb_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  acc_n;
      int  rises;
      bit  acc;
      bit  prev_l;

      // Reset state
      repeat (3) tick();
      check("reset tx_x0", tx_x0, 0);
      check("reset tx_x3", tx_x3, 0);
      check("reset xclk", tx_xclk, 0);
      check("reset ready", pix_ready, 0);
      check("reset busy", frame_busy, 0);
      reset_n = 1'b1;
      tick();
      check("xclk after release", tx_xclk, 7'b1100011);
      check("ready after release", pix_ready, 1);

      // Frame A: prefilled FIFO, normal timing, word map check
      prefill9(20'h0, acc_n);
      check("A accepted writes", acc_n, 8);
      check("A ready when full", pix_ready, 0);
      add_normal_frame();
      start_frame();
      wait_frame("A");
      check_trace("A");
      check("A stalls", stall_n, 0);
      check("A drops", drop_n, 0);
      check("A tx_x0", first_w[6:0], 7'h55);
      check("A tx_x1", first_w[13:7], 7'h5A);
      check("A tx_x2", first_w[20:14], 7'h2A);
      check("A tx_x3", first_w[27:21], 7'h38);

      // Frame B: empty FIFO mid-line plus a dropped trigger
      write_word(20'h11111, acc);
      write_word(20'h22222, acc);
      exp_code.delete();
      exp_len.delete();
      add_run(1, 3);
      add_run(7, 2);
      add_run(3, 3);
      add_run(7, 2);
      add_run(1, 2);
      add_run(7, 4);
      add_run(1, 3);
      start_frame();
      for (int i = 0; i < 7; i++) begin
         frame_trig = (i == 2);
         tick();
      end
      frame_trig = 1'b0;
      for (int i = 0; i < 6; i++) begin
         write_word(20'h30000 + 20'(i * 'h0101), acc);
      end
      wait_frame("B");
      check_trace("B");
      check("B stalls", stall_n, 3);
      check("B drops", drop_n, 1);

      // Frame C: asynchronous reset during the second line
      prefill9(20'h40000, acc_n);
      frame_trig = 1'b1;
      tick();
      frame_trig = 1'b0;
      rises  = 0;
      prev_l = 1'b0;
      for (int n = 0; n < 100 && rises < 2; n++) begin
         prev_l = tx_x3[3];
         tick();
         if (!prev_l && tx_x3[3]) rises++;
      end
      check("C reached second line", rises, 2);
      tick();
      #1 reset_n = 1'b0;
      #1;
      check("C rst tx_x0", tx_x0, 0);
      check("C rst tx_x1", tx_x1, 0);
      check("C rst tx_x2", tx_x2, 0);
      check("C rst tx_x3", tx_x3, 0);
      check("C rst xclk", tx_xclk, 0);
      check("C rst ready", pix_ready, 0);
      check("C rst busy", frame_busy, 0);
      check("C rst pulses", {line_stall, trig_drop}, 0);
      sb_q.delete();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("C xclk after release", tx_xclk, 7'b1100011);
      check("C ready after release", pix_ready, 1);
      check("C busy after release", frame_busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("C idle fval", tx_x3, 0);
      end

      // Frame D: FIFO was flushed, so it takes exactly 8 words and a full frame runs
      prefill9(20'h50000, acc_n);
      check("D accepted writes", acc_n, 8);
      check("D ready when full", pix_ready, 0);
      add_normal_frame();
      start_frame();
      wait_frame("D");
      check_trace("D");
      check("D stalls", stall_n, 0);

`ifdef CL_TEST_PATTERN_EN
      // Frame E: generated pattern, FIFO writes blocked
      tp_en = 1'b1;
      tick();
      check("E ready blocked", pix_ready, 0);
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 4; i++) begin
            sb_q.push_back({10'(2 * i + 1), 10'(2 * i)});
         end
      end
      add_normal_frame();
      start_frame();
      wait_frame("E");
      check_trace("E");
      tp_en = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
